// File: rtl/iommu_fq_writer.sv
// rtl/iommu_fq_writer.sv - IOMMU fault queue producer: packs fault events into 32-byte records
//
// Purpose: accepts fault events, writes each as a 4-beat 32-byte record into the
// memory-resident circular fault queue at {fqb_ppn,12'h000} + fqt*32, and maintains
// the tail index plus the overflow, memory-fault and interrupt-pending flags.
//
// Optional feature macro: IOMMU_FQ_DUP_FILTER_EN
//   defined   - drop an accepted event whose {cause,did,pid,pv,iotval} matches the
//               last successfully written record (no write, no flag change)
//   undefined - every accepted event is written
//
// Ports:
//   clk_i, rst_ni                 clock, synchronous active-low reset
//   fqen_i, fq_log2sz_i           queue enable, log2(entries)-1
//   fqb_ppn_i, fqh_i              queue base PPN, software head index
//   fqof_clr_i/fqmf_clr_i/fip_clr_i  one-cycle W1C strobes
//   ev_valid_i/ev_ready_o, ev_*   fault event handshake and record fields
//   wr_req_o/wr_addr_o/wr_data_o/wr_last_o/wr_gnt_i  per-beat memory write
//   wr_done_i, wr_err_i           single response per record
//   fqt_o, fq_on_o, fqof_o, fqmf_o, fip_o  tail index and status flags

module iommu_fq_writer #(
    parameter int PLEN       = 56,
    parameter int LOG2SZ_MAX = 15
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  fqen_i,
    input  logic [4:0]            fq_log2sz_i,
    input  logic [PLEN-13:0]      fqb_ppn_i,
    input  logic [LOG2SZ_MAX-1:0] fqh_i,
    input  logic                  fqof_clr_i,
    input  logic                  fqmf_clr_i,
    input  logic                  fip_clr_i,
    input  logic                  ev_valid_i,
    output logic                  ev_ready_o,
    input  logic [11:0]           ev_cause_i,
    input  logic [5:0]            ev_ttyp_i,
    input  logic [23:0]           ev_did_i,
    input  logic [19:0]           ev_pid_i,
    input  logic                  ev_pv_i,
    input  logic                  ev_priv_i,
    input  logic [63:0]           ev_iotval_i,
    input  logic [63:0]           ev_iotval2_i,
    output logic                  wr_req_o,
    output logic [PLEN-1:0]       wr_addr_o,
    output logic [63:0]           wr_data_o,
    output logic                  wr_last_o,
    input  logic                  wr_gnt_i,
    input  logic                  wr_done_i,
    input  logic                  wr_err_i,
    output logic [LOG2SZ_MAX-1:0] fqt_o,
    output logic                  fq_on_o,
    output logic                  fqof_o,
    output logic                  fqmf_o,
    output logic                  fip_o
);

    typedef enum logic [1:0] {
        S_OFF,
        S_IDLE,
        S_WRITE,
        S_RESP
    } state_t;

    localparam int KEY_W = 12 + 24 + 20 + 1 + 64;

    state_t                  state;
    logic [1:0]              beat;
    logic [11:0]             cause_q;
    logic [23:0]             did_q;
    logic [19:0]             pid_q;
    logic                    pv_q;
    logic [63:0]             iotval_q;
    logic [63:0]             iotval2_q;

    logic [5:0]              sz_raw;
    logic [5:0]              sz_eff;
    logic [LOG2SZ_MAX:0]     mask_wide;
    logic [LOG2SZ_MAX-1:0]   idx_mask;
    logic [LOG2SZ_MAX-1:0]   fqt_inc;
    logic                    full;
    logic                    accept;
    logic                    is_dup;
    logic [PLEN-1:0]         slot_addr;

    // Entry count is 2^min(log2sz+1, LOG2SZ_MAX); indices wrap through idx_mask.
    always_comb begin
        sz_raw = {1'b0, fq_log2sz_i} + 6'd1;
        sz_eff = (sz_raw > 6'(LOG2SZ_MAX)) ? 6'(LOG2SZ_MAX) : sz_raw;
        mask_wide = ({{LOG2SZ_MAX{1'b0}}, 1'b1} << sz_eff) - {{LOG2SZ_MAX{1'b0}}, 1'b1};
        idx_mask = mask_wide[LOG2SZ_MAX-1:0];
        fqt_inc = (fqt_o + {{(LOG2SZ_MAX-1){1'b0}}, 1'b1}) & idx_mask;
        full = (fqt_inc == (fqh_i & idx_mask));
        slot_addr = {fqb_ppn_i, 12'h000}
                  + {{(PLEN-LOG2SZ_MAX-5){1'b0}}, fqt_o, 5'b00000};
    end

    assign ev_ready_o = (state == S_IDLE) && fqen_i && !fqmf_o;
    assign accept     = ev_valid_i && ev_ready_o;

`ifdef IOMMU_FQ_DUP_FILTER_EN
    logic             hist_valid;
    logic [KEY_W-1:0] hist_key;

    assign is_dup = hist_valid
                 && (hist_key == {ev_cause_i, ev_did_i, ev_pid_i, ev_pv_i, ev_iotval_i});

    // History follows successful writes only; errors and queue-off forget it.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || state == S_OFF) begin
            hist_valid <= 1'b0;
            hist_key   <= '0;
        end else if (state == S_RESP && wr_done_i) begin
            if (wr_err_i) begin
                hist_valid <= 1'b0;
            end else begin
                hist_valid <= 1'b1;
                hist_key   <= {cause_q, did_q, pid_q, pv_q, iotval_q};
            end
        end
    end
`else
    assign is_dup = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state     <= S_OFF;
            beat      <= 2'd0;
            cause_q   <= '0;
            did_q     <= '0;
            pid_q     <= '0;
            pv_q      <= 1'b0;
            iotval_q  <= '0;
            iotval2_q <= '0;
            wr_req_o  <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            wr_last_o <= 1'b0;
            fqt_o     <= '0;
            fq_on_o   <= 1'b0;
            fqof_o    <= 1'b0;
            fqmf_o    <= 1'b0;
            fip_o     <= 1'b0;
        end else begin
            // Clears come first so a set in the same cycle overrides them.
            if (fqof_clr_i) fqof_o <= 1'b0;
            if (fqmf_clr_i) fqmf_o <= 1'b0;
            if (fip_clr_i)  fip_o  <= 1'b0;

            case (state)
                S_OFF: begin
                    if (fqen_i) begin
                        state   <= S_IDLE;
                        fq_on_o <= 1'b1;
                        fqt_o   <= '0;
                        fqof_o  <= 1'b0;
                        fqmf_o  <= 1'b0;
                    end
                end

                S_IDLE: begin
                    if (!fqen_i) begin
                        state   <= S_OFF;
                        fq_on_o <= 1'b0;
                        fqt_o   <= '0;
                    end else if (accept) begin
                        cause_q   <= ev_cause_i;
                        did_q     <= ev_did_i;
                        pid_q     <= ev_pid_i;
                        pv_q      <= ev_pv_i;
                        iotval_q  <= ev_iotval_i;
                        iotval2_q <= ev_iotval2_i;
                        if (is_dup) begin
                            state <= S_IDLE;
                        end else if (fqof_o || full) begin
                            fqof_o <= 1'b1;
                        end else begin
                            state     <= S_WRITE;
                            beat      <= 2'd0;
                            wr_req_o  <= 1'b1;
                            wr_addr_o <= slot_addr;
                            wr_data_o <= {ev_did_i, ev_ttyp_i, ev_priv_i, ev_pv_i,
                                          ev_pid_i, ev_cause_i};
                            wr_last_o <= 1'b0;
                        end
                    end
                end

                S_WRITE: begin
                    if (wr_gnt_i) begin
                        if (beat == 2'd3) begin
                            state     <= S_RESP;
                            wr_req_o  <= 1'b0;
                            wr_last_o <= 1'b0;
                        end else begin
                            beat      <= beat + 2'd1;
                            wr_addr_o <= wr_addr_o + PLEN'(8);
                            wr_last_o <= (beat == 2'd2);
                            case (beat)
                                2'd0:    wr_data_o <= 64'h0;
                                2'd1:    wr_data_o <= iotval_q;
                                default: wr_data_o <= iotval2_q;
                            endcase
                        end
                    end
                end

                S_RESP: begin
                    if (wr_done_i) begin
                        if (wr_err_i) begin
                            fqmf_o <= 1'b1;
                        end else begin
                            fqt_o <= fqt_inc;
                            fip_o <= 1'b1;
                        end
                        state <= S_IDLE;
                    end
                end

                default: state <= S_OFF;
            endcase
        end
    end

endmodule

// File: tb/tb_iommu_fq_writer.sv
// tb/tb_iommu_fq_writer.sv - randomized self-checking bench for iommu_fq_writer

module tb_iommu_fq_writer;

    localparam int PLEN = 56;
    localparam int LMAX = 15;

    typedef struct packed {
        logic [11:0] cause;
        logic [5:0]  ttyp;
        logic [23:0] did;
        logic [19:0] pid;
        logic        pv;
        logic        priv;
        logic [63:0] iotval;
        logic [63:0] iotval2;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, fqen;
    logic [4:0]      log2sz;
    logic [PLEN-13:0] ppn;
    logic [LMAX-1:0] fqh;
    logic            fqof_clr, fqmf_clr, fip_clr;
    logic            ev_valid, ev_ready;
    ev_t             ev;
    logic            wr_req, wr_last, wr_gnt, wr_done, wr_err;
    logic [PLEN-1:0] wr_addr;
    logic [63:0]     wr_data;
    logic [LMAX-1:0] fqt;
    logic            fq_on, fqof, fqmf, fip;

    iommu_fq_writer #(.PLEN(PLEN), .LOG2SZ_MAX(LMAX)) dut (
        .clk_i(clk), .rst_ni(rst_n), .fqen_i(fqen), .fq_log2sz_i(log2sz),
        .fqb_ppn_i(ppn), .fqh_i(fqh),
        .fqof_clr_i(fqof_clr), .fqmf_clr_i(fqmf_clr), .fip_clr_i(fip_clr),
        .ev_valid_i(ev_valid), .ev_ready_o(ev_ready),
        .ev_cause_i(ev.cause), .ev_ttyp_i(ev.ttyp), .ev_did_i(ev.did), .ev_pid_i(ev.pid),
        .ev_pv_i(ev.pv), .ev_priv_i(ev.priv), .ev_iotval_i(ev.iotval), .ev_iotval2_i(ev.iotval2),
        .wr_req_o(wr_req), .wr_addr_o(wr_addr), .wr_data_o(wr_data), .wr_last_o(wr_last),
        .wr_gnt_i(wr_gnt), .wr_done_i(wr_done), .wr_err_i(wr_err),
        .fqt_o(fqt), .fq_on_o(fq_on), .fqof_o(fqof), .fqmf_o(fqmf), .fip_o(fip)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    int           m_n;
    int           m_fqt;
    bit           m_fqof, m_fqmf, m_fip;
    bit           h_valid;
    logic [120:0] h_key;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    function automatic ev_t rand_ev();
        ev_t e;
        e.cause   = 12'($urandom);
        e.ttyp    = 6'($urandom);
        e.did     = 24'($urandom);
        e.pid     = 20'($urandom);
        e.pv      = 1'($urandom);
        e.priv    = 1'($urandom);
        e.iotval  = {$urandom, $urandom};
        e.iotval2 = {$urandom, $urandom};
        return e;
    endfunction

    task automatic enable_queue(input logic [4:0] sz);
        int s;
        log2sz = sz;
        fqen   = 1'b1;
        @(negedge clk);
        s = (int'(sz) + 1 > LMAX) ? LMAX : int'(sz) + 1;
        m_n = 1 << s;
        m_fqt = 0; m_fqof = 0; m_fqmf = 0; h_valid = 0;
        check_eq("fq_on_after_enable", fq_on, 1);
        check_eq("fqt_after_enable", fqt, 0);
    endtask

    task automatic pulse(input int which);
        if (which == 0) fqof_clr = 1'b1;
        else if (which == 1) fqmf_clr = 1'b1;
        else fip_clr = 1'b1;
        @(negedge clk);
        fqof_clr = 1'b0; fqmf_clr = 1'b0; fip_clr = 1'b0;
        if (which == 0) m_fqof = 0;
        else if (which == 1) m_fqmf = 0;
        else m_fip = 0;
    endtask

    task automatic do_event(input ev_t e, input bit err, input int lat,
                            input bit clr_fip, input int drop_beat);
        int              t;
        bit              dup;
        logic [120:0]    key;
        logic [PLEN-1:0] base;
        logic [63:0]     exp_d [4];
        t = 0;
        while (ev_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq("ready_before_event", ev_ready, 1);
        ev = e;
        ev_valid = 1'b1;
        @(negedge clk);
        ev_valid = 1'b0;

        key = {e.cause, e.did, e.pid, e.pv, e.iotval};
        dup = 0;
`ifdef IOMMU_FQ_DUP_FILTER_EN
        dup = h_valid && (h_key == key);
`endif
        if (dup || m_fqof || ((m_fqt + 1) % m_n) == int'(fqh)) begin
            if (!dup) m_fqof = 1;
            check_eq("drop_no_req", wr_req, 0);
            check_eq("drop_fqof", fqof, m_fqof);
            check_eq("drop_fqt", fqt, m_fqt);
            return;
        end

        base = {ppn, 12'h000} + PLEN'(m_fqt * 32);
        exp_d[0] = {e.did, e.ttyp, e.priv, e.pv, e.pid, e.cause};
        exp_d[1] = 64'h0;
        exp_d[2] = e.iotval;
        exp_d[3] = e.iotval2;
        for (int b = 0; b < 4; b++) begin
            int stall = $urandom_range(0, 2);
            repeat (stall) begin
                wr_gnt = 1'b0;
                @(negedge clk);
            end
            if (b == drop_beat) fqen = 1'b0;
            check_eq($sformatf("beat%0d_req", b), wr_req, 1);
            check_eq($sformatf("beat%0d_addr", b), wr_addr, base + PLEN'(b * 8));
            check_eq($sformatf("beat%0d_data", b), wr_data, exp_d[b]);
            check_eq($sformatf("beat%0d_last", b), wr_last, (b == 3) ? 1 : 0);
            wr_gnt = 1'b1;
            @(negedge clk);
            wr_gnt = 1'b0;
        end
        check_eq("resp_req_low", wr_req, 0);
        repeat (lat) @(negedge clk);
        check_eq("fqt_before_done", fqt, m_fqt);
        wr_done = 1'b1;
        wr_err  = err;
        fip_clr = clr_fip;
        @(negedge clk);
        wr_done = 1'b0; wr_err = 1'b0; fip_clr = 1'b0;
        if (clr_fip) m_fip = 0;
        if (err) begin
            m_fqmf  = 1;
            h_valid = 0;
        end else begin
            m_fqt   = (m_fqt + 1) % m_n;
            m_fip   = 1;
            h_valid = 1;
            h_key   = key;
        end
        check_eq("done_fqt", fqt, m_fqt);
        check_eq("done_fip", fip, m_fip);
        check_eq("done_fqmf", fqmf, m_fqmf);
        check_eq("done_ready", ev_ready, (fqen && !m_fqmf) ? 1 : 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        ev_t e;
        rst_n = 1'b0; fqen = 1'b0; log2sz = 5'd2; ppn = 44'h80000; fqh = '0;
        fqof_clr = 1'b0; fqmf_clr = 1'b0; fip_clr = 1'b0;
        ev_valid = 1'b0; ev = '0; wr_gnt = 1'b0; wr_done = 1'b0; wr_err = 1'b0;
        m_fip = 0;
        repeat (3) @(negedge clk);
        check_eq("rst_ev_ready", ev_ready, 0);
        check_eq("rst_wr_req", wr_req, 0);
        check_eq("rst_wr_addr", wr_addr, 0);
        check_eq("rst_wr_data", wr_data, 0);
        check_eq("rst_wr_last", wr_last, 0);
        check_eq("rst_fqt", fqt, 0);
        check_eq("rst_fq_on", fq_on, 0);
        check_eq("rst_fqof", fqof, 0);
        check_eq("rst_fqmf", fqmf, 0);
        check_eq("rst_fip", fip, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("off_fq_on", fq_on, 0);

        // First record at the queue base
        enable_queue(5'd2);
        e = rand_ev();
        e.cause = 12'd13; e.did = 24'd5; e.iotval = 64'h1000;
        do_event(e, 1'b0, 1, 1'b0, -1);
        check_eq("first_fqt", fqt, 1);
        check_eq("first_fip", fip, 1);

        // Fill to N-1 entries, then overflow
        repeat (6) do_event(rand_ev(), 1'b0, $urandom_range(0, 3), 1'b0, -1);
        check_eq("filled_fqt", fqt, 7);
        do_event(rand_ev(), 1'b0, 0, 1'b0, -1);
        check_eq("overflow_fqof", fqof, 1);
        pulse(0);
        check_eq("fqof_cleared", fqof, 0);
        fqh = 3;
        do_event(rand_ev(), 1'b0, 2, 1'b0, -1);
        check_eq("wrap_fqt", fqt, 0);

        // Memory fault blocks further events until cleared
        do_event(rand_ev(), 1'b1, 1, 1'b0, -1);
        repeat (3) begin
            @(negedge clk);
            check_eq("fqmf_blocks_ready", ev_ready, 0);
        end
        pulse(1);
        check_eq("fqmf_clr_ready", ev_ready, 1);

        // fip clear loses to a coincident set
        pulse(2);
        check_eq("fip_cleared", fip, 0);
        do_event(rand_ev(), 1'b0, 1, 1'b1, -1);
        check_eq("fip_set_wins", fip, 1);

        // Disable mid-transfer: record completes, then queue turns off
        do_event(rand_ev(), 1'b0, 1, 1'b0, 2);
        @(negedge clk);
        m_fqt = 0; h_valid = 0;
        check_eq("disable_fq_on", fq_on, 0);
        check_eq("disable_fqt", fqt, 0);

        // Two identical events
        enable_queue(5'd2);
        e = rand_ev();
        do_event(e, 1'b0, 1, 1'b0, -1);
        do_event(e, 1'b0, 1, 1'b0, -1);
`ifdef IOMMU_FQ_DUP_FILTER_EN
        check_eq("dup_fqt", fqt, 1);
`else
        check_eq("dup_fqt", fqt, 2);
`endif

        // Randomized traffic over small queues
        for (int r = 0; r < 3; r++) begin
            fqen = 1'b0;
            @(negedge clk);
            @(negedge clk);
            enable_queue(5'($urandom_range(0, 3)));
            for (int i = 0; i < 20; i++) begin
                if (m_fqmf) pulse(1);
                if (m_fqof && ($urandom_range(0, 1) == 1)) pulse(0);
                fqh = LMAX'($urandom_range(0, m_n - 1));
                do_event(rand_ev(), ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                         ($urandom_range(0, 3) == 0), -1);
            end
            check_eq("rand_fqof", fqof, m_fqof);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/iommu_fq_writer.md
# iommu_fq_writer

Producer side of the IOMMU fault queue (FQ). It accepts fault events from the translation and context-walk logic and packs each one into a 32-byte fault record. It writes the record into the memory-resident circular FQ, which software consumes, and maintains the tail pointer, overflow, memory-fault and interrupt-pending flags. It sits between the IOMMU fault reporting logic and the memory write port, next to the register file that holds fqb, fqh and fqcsr.

## Interface
- PLEN, 56: physical address width.
- LOG2SZ_MAX, 15: largest supported log2 of the queue entry count; it sets the fqt/fqh width.
- clk_i in 1: clock.
- rst_ni in 1: synchronous, active-low reset.
- fqen_i in 1: queue enable (fqcsr.fqen).
- fq_log2sz_i in 5: log2(entries)-1.
- fqb_ppn_i in PLEN-12: queue base PPN.
- fqh_i in LOG2SZ_MAX: software head index.
- fqof_clr_i, fqmf_clr_i, fip_clr_i in 1: one-cycle W1C strobes.
- ev_valid_i in 1 / ev_ready_o out 1: event handshake.
- ev_cause_i 12, ev_ttyp_i 6, ev_did_i 24, ev_pid_i 20, ev_pv_i 1, ev_priv_i 1, ev_iotval_i 64, ev_iotval2_i 64: record fields; custom and reserved fields are driven 0.
- wr_req_o out 1, wr_addr_o out PLEN, wr_data_o out 64, wr_last_o out 1, wr_gnt_i in 1: per-beat write request.
- wr_done_i in 1, wr_err_i in 1: single response per record.
- fqt_o out LOG2SZ_MAX: tail index.
- fq_on_o, fqof_o, fqmf_o, fip_o out 1: status flags.

## Operation
- Queue size is N = 2^min(fq_log2sz_i+1, LOG2SZ_MAX) entries. All index arithmetic is taken mod N.
- FSM has four states: OFF, IDLE, WRITE, RESP.
- OFF: when fqen_i=1, move to IDLE, set fq_on_o, and clear fqt, fqof and fqmf.
- IDLE: if fqen_i=0, move to OFF and clear fq_on_o and fqt. Otherwise ev_ready_o = !fqmf_o.
- On an event handshake, the fields are latched.
  - If fqof_o=1 or (fqt+1) mod N == fqh_i, the record is dropped and fqof_o is set; the FSM stays in IDLE.
  - Otherwise the FSM moves to WRITE.
- WRITE: issues 4 beats at address {fqb_ppn_i,12'h000} + fqt*32 + beat*8.
  - Beat 0: {did, ttyp, priv, pv, pid, cause}, with cause in bits [11:0].
  - Beat 1: 64'h0.
  - Beat 2: iotval.
  - Beat 3: iotval2, with wr_last_o=1.
  - A beat advances on wr_req_o && wr_gnt_i. After beat 3 the FSM moves to RESP.
- RESP: waits for wr_done_i.
  - wr_err_i=0: fqt advances by 1 mod N and fip_o is set.
  - wr_err_i=1: fqmf_o is set and fqt is unchanged.
  - Then the FSM returns to IDLE.
- Taking fqen_i low during WRITE or RESP does not abort the transfer; it completes, then IDLE sends the FSM to OFF.
- A W1C strobe coincident with a set event: the set wins.
- fqh_i is sampled only at accept time.

## Timing
- Reset values: ev_ready_o=0, wr_req_o=0, wr_addr_o=0, wr_data_o=0, wr_last_o=0, fqt_o=0, fq_on_o=0, fqof_o=0, fqmf_o=0, fip_o=0. The FSM resets to OFF.
- fq_on_o rises 1 cycle after fqen_i rises.
- wr_req_o rises the cycle after the accept. The minimum is 4 cycles from accept to RESP with wr_gnt_i tied high.
- fqt_o and fip_o update the cycle after wr_done_i. ev_ready_o is re-asserted in that same cycle.
- Throughput is one record per (4 + response latency + 2) cycles; at most one record is in flight.
- Reset asserted mid-write abandons the transfer immediately; no response is awaited.

## Configuration
- IOMMU_FQ_DUP_FILTER_EN:
  - Defined: the block keeps {cause, did, pid, pv, iotval} of the last successfully written record. An accepted event with identical fields is dropped silently: no write, fqof and fqt unchanged. The history is invalidated on OFF, on a write error, and on reset.
  - Undefined: no history is kept and every accepted event is written.

## Test plan
- Enable with log2sz=2 (N=8) and base PPN 0x80000; inject cause=13, did=5, iotval=0x1000 -> 4 beats at 0x80000000/08/10/18, beat0 = {24'd5,...,12'd13}; after wr_done, fqt=1 and fip=1.
- With fqh=0, write 7 records, then inject an 8th -> no write request and fqof=1; pulse fqof_clr, set fqh=3, inject -> write at slot 7, then fqt wraps to 0.
- Return wr_err_i=1 -> fqmf=1, fqt unchanged, ev_ready_o=0; pulse fqmf_clr -> ev_ready_o=1.
- Drop fqen_i during beat 2 -> beats 3 and the response complete, then fq_on_o=0 and fqt=0.
- Pulse fip_clr in the same cycle as a successful wr_done -> fip_o stays 1.
- With IOMMU_FQ_DUP_FILTER_EN defined, send two identical events -> exactly one write and fqt=1; without the macro -> two writes and fqt=2.
